// File: rtl/alu_mul_seq_if.sv
// Request/result handshake plus shared-ALU port bundle for alu_mul_seq.
// slave = multiplier side, master = requester/ALU side.
interface alu_mul_seq_if;
  logic        start;
  logic [15:0] opA;
  logic [15:0] opB;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        ovf;
  logic [3:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_result;
  logic [3:0]  alu_cc;

  modport slave (
    input  start, opA, opB, alu_result, alu_cc,
    output busy, done, product, ovf, alu_op, alu_a, alu_b
  );

  modport master (
    output start, opA, opB, alu_result, alu_cc,
    input  busy, done, product, ovf, alu_op, alu_a, alu_b
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Sequential 16x16 shift-and-add multiplier that borrows an external ALU
// for each add and shift step; low 16 product bits plus overflow flag.
module alu_mul_seq #(
  parameter logic [3:0] OP_ADD  = 4'b0001,
  parameter logic [3:0] OP_SHL  = 4'b0011,
  parameter logic [3:0] OP_IDLE = 4'b0000
) (
  input logic         clk,
  input logic         reset,
  alu_mul_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic        ovf_acc_q, ovf_acc_d;
  logic [15:0] product_q, product_d;
  logic        ovf_q, ovf_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        unused_cc;

  assign unused_cc = ^{bus.alu_cc[3:2], bus.alu_cc[0]};

  always_comb begin
    bus.alu_op = OP_IDLE;
    bus.alu_a  = '0;
    bus.alu_b  = '0;
    case (state_q)
      ADD: begin
        bus.alu_op = OP_ADD;
        bus.alu_a  = acc_q;
        bus.alu_b  = mcand_q;
      end
      SHIFT: begin
        bus.alu_op = OP_SHL;
        bus.alu_a  = 16'd1;
        bus.alu_b  = mcand_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    ovf_acc_d = ovf_acc_q;
    product_d = product_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d     = '0;
          mcand_d   = bus.opA;
          mplier_d  = bus.opB;
          ovf_acc_d = 1'b0;
          if (bus.opB == 16'd0)   state_d = DONE;
          else if (bus.opB[0])    state_d = ADD;
          else                    state_d = SHIFT;
        end
      end
      ADD: begin
        acc_d     = bus.alu_result;
        ovf_acc_d = ovf_acc_q | bus.alu_cc[1];
        state_d   = (mplier_q[15:1] == 15'd0) ? DONE : SHIFT;
      end
      SHIFT: begin
        // Next-state decode looks at the pre-shift multiplier, so bit 1 is
        // the bit that lands in position 0 after this shift.
        mcand_d   = bus.alu_result;
        mplier_d  = mplier_q >> 1;
        ovf_acc_d = ovf_acc_q | mcand_q[15];
        if (mplier_q[15:1] == 15'd0) state_d = DONE;
        else if (mplier_q[1])        state_d = ADD;
        else                         state_d = SHIFT;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Visible results only change on DONE entry and hold until the next one.
    if (state_d == DONE && state_q != DONE) begin
      product_d = acc_d;
      ovf_d     = ovf_acc_d;
    end
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      ovf_acc_q <= 1'b0;
      product_q <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      ovf_acc_q <= ovf_acc_d;
      product_q <= product_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 Parameter OP_ADD, default 4'b0001, ALU opcode driven for add cycles.
REQ-002 Parameter OP_SHL, default 4'b0011, ALU opcode driven for shift-left cycles.
REQ-003 Parameter OP_IDLE, default 4'b0000, ALU opcode driven when no ALU cycle is in use.
REQ-004 The block SHALL use one clock, with a synchronous, active-high reset.
REQ-005 clk  in  1  clock; all state changes on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  request; sampled only in IDLE.
REQ-008 opA  in  16  multiplicand (unsigned).
REQ-009 opB  in  16  multiplier (unsigned).
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  single-cycle pulse; high only in DONE.
REQ-012 product  out  16  low 16 bits of opA*opB; held from DONE until the next accepted start.
REQ-013 ovf  out  1  set when the true 32-bit product exceeds 16 bits; held with product.
REQ-014 alu_op  out  4  opcode to the shared ALU.
REQ-015 alu_a  out  16  ALU valA (add: accumulator; shift: shift amount).
REQ-016 alu_b  out  16  ALU valB (add: multiplicand; shift: operand to shift).
REQ-017 alu_result  in  16  ALU result, combinational from alu_op/alu_a/alu_b in the same cycle.
REQ-018 alu_cc  in  4  ALU flags {N,Z,C,V}; C is bit 1.

Function
REQ-019 The states SHALL be IDLE, ADD, SHIFT and DONE; internal registers are acc, mcand and mplier (16 bits each) plus ovf.
REQ-020 In IDLE with start=1: acc<=0, mcand<=opA, mplier<=opB, ovf<=0; next state is DONE if opB==0, ADD if opB[0]==1, otherwise SHIFT.
REQ-021 In IDLE with start=0: hold all registers; alu_op=OP_IDLE, alu_a=0, alu_b=0.
REQ-022 In ADD: alu_op=OP_ADD, alu_a=acc, alu_b=mcand; acc<=alu_result; ovf<=ovf|alu_cc[1]; next state is DONE if (mplier>>1)==0, otherwise SHIFT.
REQ-023 In SHIFT: alu_op=OP_SHL, alu_a=16'd1, alu_b=mcand; mcand<=alu_result; mplier<=mplier>>1; ovf<=ovf|mcand[15].
REQ-024 The next state after SHIFT SHALL be DONE if (mplier>>1)==0, ADD if bit 1 of mplier==1, otherwise SHIFT.
REQ-025 Shifts SHALL occur only while (mplier>>1) is nonzero, so any multiplicand bit lost from position 15 is a true overflow.
REQ-026 In DONE: product=acc, done=1, alu_op=OP_IDLE; the next state SHALL be IDLE unconditionally.
REQ-027 start SHALL be ignored in ADD, SHIFT and DONE; operand changes after acceptance SHALL have no effect.
REQ-028 Latency from accepting start to the done cycle SHALL be 1 + popcount(opB) + (index of the highest set bit of opB), and 1 cycle when opB==0; the maximum is 32 cycles (opB=16'hFFFF).
REQ-029 product and ovf SHALL update only on entry to DONE and hold through IDLE.
REQ-030 Every cycle SHALL issue at most one ALU operation; the ALU SHALL be free (alu_op=OP_IDLE) in IDLE and DONE.

Reset
REQ-031 reset=1 SHALL force state IDLE; busy=0, done=0, product=0, ovf=0, acc=0, mcand=0 and mplier=0 on the next edge.
REQ-032 reset SHALL take priority over start and over any operation in progress; an aborted operation produces no done pulse.
REQ-033 The first start after reset deasserts SHALL be accepted normally.

Verification
REQ-034 opA=3, opB=5 -> ADD,SHIFT,SHIFT,ADD,DONE; done in cycle 5 after acceptance; product=16'd15, ovf=0.
REQ-035 opA=16'h1234, opB=0 -> done in cycle 1, product=0, ovf=0, no ADD or SHIFT cycles issued.
REQ-036 opA=16'h0100, opB=16'h0100 -> 8 SHIFTs then ADD; product=16'h0000, ovf=1; done in cycle 10.
REQ-037 opA=16'hFFFF, opB=16'hFFFF -> 16 ADDs and 15 SHIFTs; done in cycle 32; product=16'h0001, ovf=1.
REQ-038 reset asserted in the third ADD/SHIFT cycle of opA=7, opB=16'h00FF -> next cycle busy=0, product=0, no done pulse; a following start with opA=7, opB=6 -> product=16'd42.
REQ-039 start held high through a whole operation -> exactly one done per accepted start, with re-acceptance only in IDLE (one cycle after DONE); alu_op=OP_IDLE in every IDLE and DONE cycle.
